// File: rtl/add_out_collector_pkg.sv
// Shared constants for the quantized ADD output collector: element widths, lane count
// and the job state encodings.
package add_out_collector_pkg;

    localparam int INT8_SIZE = 8;
    localparam int ADD_LANES = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/add_out_collector_if.sv
// Ready/valid vector stream leaving the collector: lane data, per-lane keep and a
// job-final flag.
interface add_out_collector_if
    import add_out_collector_pkg::*;
#(
    parameter int MAX_VECTOR_SIZE = ADD_LANES
) ();

    logic [INT8_SIZE*MAX_VECTOR_SIZE-1:0] tdata;
    logic [MAX_VECTOR_SIZE-1:0]           tkeep;
    logic                                 tlast;
    logic                                 tvalid;
    logic                                 tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/add_out_collector_sync_fifo.sv
// Synchronous FIFO whose head word lives in an output register backed by a storage
// array; total capacity is DEPTH entries including the head.
module add_out_collector_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_mem_count;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;

    logic w_load_out;
    logic w_mem_empty;
    logic w_bypass;
    logic w_mem_wr;
    logic w_mem_rd;

    // The head register refills whenever it is empty or being popped; a write that
    // finds the array empty goes straight into it.
    assign w_load_out  = !r_out_valid || i_rd_en;
    assign w_mem_empty = (r_mem_count == '0);
    assign w_bypass    = i_wr_en && w_load_out && w_mem_empty;
    assign w_mem_wr    = i_wr_en && !w_bypass;
    assign w_mem_rd    = w_load_out && !w_mem_empty;

    // NOTE: the storage array has no reset; only pointers and counts need a known
    // value, which keeps the array mappable onto RAM.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_mem_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_mem_wr, w_mem_rd})
                2'b10:   r_mem_count <= r_mem_count + CNT_W'(1);
                2'b01:   r_mem_count <= r_mem_count - CNT_W'(1);
                default: r_mem_count <= r_mem_count;
            endcase
            if (w_load_out) begin
                if (!w_mem_empty) begin
                    r_out_data  <= r_mem[r_rd_ptr];
                    r_out_valid <= 1'b1;
                end else if (i_wr_en) begin
                    r_out_data  <= i_wr_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign o_rd_data = r_out_data;
    assign o_empty   = !r_out_valid;
    assign o_count   = r_mem_count + CNT_W'(r_out_valid);
    assign o_full    = (o_count == CNT_W'(DEPTH));

endmodule

// File: rtl/add_out_collector.sv
// Collects 8-lane int8 ADD results into a FIFO, streams them out with keep/last, and
// hands credits back to the issue logic so the ADD pipeline cannot overrun the buffer.
module add_out_collector
    import add_out_collector_pkg::*;
#(
    parameter int MAX_VECTOR_SIZE = ADD_LANES,
    parameter int FIFO_DEPTH      = 16,
    parameter int CNT_W           = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [CNT_W-1:0]                     total_len_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    input  logic                                 issue_i,
    output logic                                 issue_ok_o,
    input  logic [INT8_SIZE*MAX_VECTOR_SIZE-1:0] add_data_i,
    input  logic                                 add_valid_i,
    add_out_collector_if.master                  m_axis,
    output logic                                 overflow_o,
    output logic                                 stray_o
);

    localparam int DATA_W  = INT8_SIZE * MAX_VECTOR_SIZE;
    localparam int ENTRY_W = DATA_W + MAX_VECTOR_SIZE + 1;
    localparam int CRED_W  = $clog2(FIFO_DEPTH + 1);
    localparam int LANE_SH = $clog2(MAX_VECTOR_SIZE);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(FIFO_DEPTH);

    state_t              r_state;
    logic [CNT_W-1:0]    r_rem;
    logic [CNT_W:0]      r_vec_left;
    logic [CRED_W-1:0]   r_credits;
    logic                r_issue_ok;
    logic                r_overflow;
    logic                r_stray;

    logic [CNT_W:0]              w_vec_total;
    logic [MAX_VECTOR_SIZE-1:0]  w_keep;
    logic [DATA_W-1:0]           w_lane_data;
    logic                        w_last;
    logic                        w_push_req;
    logic                        w_push;
    logic                        w_push_drop;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_credit_err;
    logic [CRED_W-1:0]           w_credits_nxt;
    logic [ENTRY_W-1:0]          w_rd_entry;
    logic [CRED_W-1:0]           w_unused_count;

    // Extra top bit keeps len + 7 from wrapping for lengths near 2^CNT_W - 1.
    assign w_vec_total = ({1'b0, total_len_i} + (CNT_W+1)'(MAX_VECTOR_SIZE - 1)) >> LANE_SH;

    // NOTE: every always_comb output gets a default before any conditional logic so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_keep      = '0;
        w_lane_data = '0;
        for (int i = 0; i < MAX_VECTOR_SIZE; i++) begin
            w_keep[i] = (r_rem > CNT_W'(i));
            w_lane_data[i*INT8_SIZE +: INT8_SIZE] =
                w_keep[i] ? add_data_i[i*INT8_SIZE +: INT8_SIZE] : '0;
        end
    end

    assign w_last      = (r_rem <= CNT_W'(MAX_VECTOR_SIZE));
    assign w_push_req  = add_valid_i && (r_state == ST_RUN);
    assign w_pop       = !w_empty && m_axis.tready;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_push_drop = w_push_req && !w_push;

    add_out_collector_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data ({w_lane_data, w_keep, w_last}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_entry),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_unused_count)
    );

    assign m_axis.tdata  = w_rd_entry[ENTRY_W-1 -: DATA_W];
    assign m_axis.tkeep  = w_rd_entry[MAX_VECTOR_SIZE:1];
    assign m_axis.tlast  = w_rd_entry[0];
    assign m_axis.tvalid = !w_empty;

    // A simultaneous issue and pop cancel; an issue with no credit left is an error
    // and the counter holds at zero.
    always_comb begin
        w_credits_nxt = r_credits;
        if (issue_i && !w_pop) begin
            if (r_credits != '0) begin
                w_credits_nxt = r_credits - CRED_W'(1);
            end
        end else if (w_pop && !issue_i) begin
            if (r_credits != CRED_FULL) begin
                w_credits_nxt = r_credits + CRED_W'(1);
            end
        end
    end

    assign w_credit_err = issue_i && (r_credits == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_vec_left <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_rem      <= total_len_i;
                        r_vec_left <= w_vec_total;
                        r_state    <= (total_len_i == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_push_req) begin
                        r_rem      <= w_last ? '0 : r_rem - CNT_W'(MAX_VECTOR_SIZE);
                        r_vec_left <= r_vec_left - (CNT_W+1)'(1);
                        if (r_vec_left == (CNT_W+1)'(1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && m_axis.tlast) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits  <= CRED_FULL;
            r_issue_ok <= 1'b1;
            r_overflow <= 1'b0;
            r_stray    <= 1'b0;
        end else begin
            r_credits  <= w_credits_nxt;
            r_issue_ok <= (w_credits_nxt != '0);
            if (w_push_drop || w_credit_err) begin
                r_overflow <= 1'b1;
            end
            if (add_valid_i && (r_state != ST_RUN)) begin
                r_stray <= 1'b1;
            end
        end
    end

    assign busy_o     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done_o     = (r_state == ST_DONE);
    assign issue_ok_o = r_issue_ok;
    assign overflow_o = r_overflow;
    assign stray_o    = r_stray;

endmodule

// File: tb/tb_add_out_collector.sv
// Bench for add_out_collector: directed scenarios with literal expectations plus
// randomized jobs, all compared every cycle against a queue-based reference model.
module tb_add_out_collector;
    import add_out_collector_pkg::*;

    localparam int MVS   = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] total_len;
    logic        busy;
    logic        done;
    logic        issue;
    logic        issue_ok;
    logic [63:0] add_data;
    logic        add_valid;
    logic        overflow;
    logic        stray;

    int n_vec = 0;
    int n_bad = 0;

    add_out_collector_if #(.MAX_VECTOR_SIZE(MVS)) m_axis ();

    add_out_collector #(
        .MAX_VECTOR_SIZE (MVS),
        .FIFO_DEPTH      (DEPTH),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .total_len_i (total_len),
        .busy_o      (busy),
        .done_o      (done),
        .issue_i     (issue),
        .issue_ok_o  (issue_ok),
        .add_data_i  (add_data),
        .add_valid_i (add_valid),
        .m_axis      (m_axis),
        .overflow_o  (overflow),
        .stray_o     (stray)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int k);
        logic [7:0] b;
        b = 8'(k * 17 + 3);
        return {8{b}};
    endfunction

    // Reference model: the job as "elements still owed" and the buffer as a queue of beats.
    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t  mq[$];
    int     m_phase;   // 0 idle, 1 collecting, 2 draining, 3 finishing
    longint m_rem;
    longint m_vleft;
    int     m_cr;
    bit     m_ovf;
    bit     m_stray;
    bit     cmp_en = 1'b0;

    always @(posedge clk) begin
        bit    pop;
        bit    pop_last;
        bit    was_full;
        int    ph;
        int    nk;
        beat_t b;
        if (rst) begin
            mq.delete();
            m_phase = 0;
            m_cr    = DEPTH;
            m_ovf   = 1'b0;
            m_stray = 1'b0;
            cmp_en  = 1'b1;
        end else begin
            ph       = m_phase;
            pop      = (mq.size() != 0) && m_axis.tready;
            pop_last = pop && mq[0].l;
            was_full = (mq.size() >= DEPTH);
            if (issue && m_cr == 0) m_ovf = 1'b1;
            if (issue && !pop && m_cr > 0) m_cr--;
            else if (pop && !issue && m_cr < DEPTH) m_cr++;
            if (pop) void'(mq.pop_front());
            if (add_valid && ph != 1) m_stray = 1'b1;
            case (ph)
                0: if (start) begin
                    m_rem   = longint'(total_len);
                    m_vleft = (m_rem + 7) / 8;
                    m_phase = (total_len == 0) ? 3 : 1;
                end
                1: if (add_valid) begin
                    nk  = (m_rem >= 8) ? 8 : int'(m_rem);
                    b.k = 8'((1 << nk) - 1);
                    b.d = (nk == 8) ? add_data : (add_data & ((64'd1 << (8 * nk)) - 64'd1));
                    b.l = (m_rem <= 8);
                    if (!was_full || pop) mq.push_back(b);
                    else m_ovf = 1'b1;
                    m_rem = (m_rem > 8) ? m_rem - 8 : 0;
                    m_vleft--;
                    if (m_vleft == 0) m_phase = 2;
                end
                2: if (pop_last) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("tvalid", m_axis.tvalid, mq.size() != 0);
            if (mq.size() != 0) begin
                check("tdata", m_axis.tdata, mq[0].d);
                check("tkeep", m_axis.tkeep, mq[0].k);
                check("tlast", m_axis.tlast, mq[0].l);
            end
            check("busy", busy, (m_phase == 1) || (m_phase == 2));
            check("done", done, m_phase == 3);
            check("issue_ok", issue_ok, m_cr != 0);
            check("overflow", overflow, m_ovf);
            check("stray", stray, m_stray);
        end
    end

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(name, done, 1'b1);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_job(input int len, input int lat, input int rdy_pct);
        int         to_issue;
        int         n;
        logic [3:0] hist;
        logic [3:0] cur;
        to_issue  = (len + 7) / 8;
        hist      = '0;
        start     = 1'b1;
        total_len = 32'(len);
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 600) begin
            issue = issue_ok && (to_issue > 0) && ($urandom_range(0, 3) != 0);
            if (issue) to_issue--;
            cur           = {hist[2:0], issue};
            add_valid     = cur[lat];
            add_data      = {$urandom, $urandom};
            m_axis.tready = ($urandom_range(0, 99) < rdy_pct);
            hist          = cur;
            tick();
            n++;
        end
        issue     = 1'b0;
        add_valid = 1'b0;
        check("job_done", done, 1'b1);
        tick();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        total_len     = '0;
        issue         = 1'b0;
        add_data      = '0;
        add_valid     = 1'b0;
        m_axis.tready = 1'b0;
        tick();
        tick();
        check("rst_tvalid", m_axis.tvalid, 1'b0);
        check("rst_tdata", m_axis.tdata, 64'h0);
        check("rst_issue_ok", issue_ok, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_flags", {overflow, stray}, 2'b00);
        rst = 1'b0;

        // len=24, three full vectors back to back
        m_axis.tready = 1'b1;
        start = 1'b1; total_len = 32'd24;
        tick();
        start = 1'b0;
        check("t24_busy", busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            issue = 1'b1; add_valid = 1'b1; add_data = pat(k);
            tick();
            check("t24_tvalid", m_axis.tvalid, 1'b1);
            check("t24_tkeep", m_axis.tkeep, 8'hFF);
            check("t24_tlast", m_axis.tlast, k == 2);
            check("t24_tdata", m_axis.tdata, pat(k));
        end
        issue = 1'b0; add_valid = 1'b0;
        tick();
        check("t24_done", done, 1'b1);
        check("t24_tvalid_end", m_axis.tvalid, 1'b0);
        tick();
        check("t24_done_pulse", done, 1'b0);

        // len=13, partial second vector
        start = 1'b1; total_len = 32'd13;
        tick();
        start = 1'b0;
        issue = 1'b1; add_valid = 1'b1; add_data = 64'h7F7F_7F7F_7F7F_7F7F;
        tick();
        check("t13_keep1", m_axis.tkeep, 8'hFF);
        check("t13_last1", m_axis.tlast, 1'b0);
        tick();
        check("t13_keep2", m_axis.tkeep, 8'h1F);
        check("t13_data2", m_axis.tdata, 64'h0000_007F_7F7F_7F7F);
        check("t13_last2", m_axis.tlast, 1'b1);
        issue = 1'b0; add_valid = 1'b0;
        wait_done("t13_done", 20);
        tick();

        // backpressure: credits run out, one pop returns one
        m_axis.tready = 1'b0;
        start = 1'b1; total_len = 32'd64;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue = 1'b1; add_valid = 1'b1; add_data = pat(k);
            tick();
            check("bp_issue_ok", issue_ok, k < 3);
        end
        issue = 1'b0; add_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_stall_data", m_axis.tdata, pat(0));
        end
        m_axis.tready = 1'b1;
        tick();
        m_axis.tready = 1'b0;
        check("bp_credit_back", issue_ok, 1'b1);
        check("bp_next_data", m_axis.tdata, pat(1));
        m_axis.tready = 1'b1;
        for (int k = 4; k < 8; k++) begin
            issue = 1'b1; add_valid = 1'b1; add_data = pat(k);
            tick();
            check("bp_order", m_axis.tdata, pat(k - 2));
        end
        issue = 1'b0; add_valid = 1'b0;
        wait_done("bp_done", 20);
        tick();

        // len=0: immediate completion
        start = 1'b1; total_len = 32'd0;
        tick();
        start = 1'b0;
        check("z_done", done, 1'b1);
        check("z_busy", busy, 1'b0);
        check("z_tvalid", m_axis.tvalid, 1'b0);
        tick();
        check("z_done_pulse", done, 1'b0);

        // error flags
        add_valid = 1'b1; add_data = pat(9);
        tick();
        add_valid = 1'b0;
        check("err_stray", stray, 1'b1);
        m_axis.tready = 1'b0;
        start = 1'b1; total_len = 32'd80;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            add_valid = 1'b1; add_data = pat(k);
            tick();
            check("err_overflow", overflow, k == 4);
        end
        add_valid = 1'b0;
        reset_pulse();
        check("err_clear", {overflow, stray}, 2'b00);
        check("err_issue_ok", issue_ok, 1'b1);
        for (int k = 0; k < 4; k++) begin
            issue = 1'b1;
            tick();
            check("err_credits_full", issue_ok, k < 3);
        end
        issue = 1'b0;

        // reset mid-job with buffered vectors
        reset_pulse();
        start = 1'b1; total_len = 32'd40;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            issue = 1'b1; add_valid = 1'b1; add_data = pat(k + 3);
            tick();
        end
        issue = 1'b0; add_valid = 1'b0;
        check("mid_buffered", m_axis.tvalid, 1'b1);
        reset_pulse();
        check("mid_tvalid", m_axis.tvalid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_issue_ok", issue_ok, 1'b1);
        start = 1'b1; total_len = 32'd8;
        tick();
        start = 1'b0;
        issue = 1'b1; add_valid = 1'b1; add_data = pat(5);
        tick();
        issue = 1'b0; add_valid = 1'b0;
        check("mid_new_keep", m_axis.tkeep, 8'hFF);
        check("mid_new_last", m_axis.tlast, 1'b1);
        check("mid_new_data", m_axis.tdata, pat(5));
        m_axis.tready = 1'b1;
        wait_done("mid_new_done", 20);
        tick();

        // randomized jobs
        reset_pulse();
        for (int j = 0; j < 30; j++) begin
            int pct;
            case ($urandom_range(0, 2))
                0:       pct = 100;
                1:       pct = 60;
                default: pct = 20;
            endcase
            run_job(int'($urandom_range(0, 70)), int'($urandom_range(0, 3)), pct);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/add_out_collector.md
Name: add_out_collector

Overview:
- Downstream stage of the vectorised quantized ADD unit.
- Captures the unit's 8-lane int8 result vectors, which arrive with no backpressure, and buffers them in a FIFO.
- Issues them on a ready/valid output stream with per-lane keep and a last flag.
- Returns credits to the issue logic so the ADD pipeline can never overrun the buffer, whatever its latency.

Parameters:
- MAX_VECTOR_SIZE, 8, int8 lanes per vector; must match the ADD unit.
- FIFO_DEPTH, 16, vector entries buffered; power of two, ≥2.
- CNT_W, 32, width of the element-count registers.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start_i  in  1  one-cycle job start; sampled only in IDLE.
- total_len_i  in  CNT_W  int8 elements in the job; sampled with start_i.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse when the job completes.
- issue_i  in  1  upstream is asserting valid_in into ADD this cycle (consumes one credit).
- issue_ok_o  out  1  at least one credit available; upstream may issue.
- add_data_i  in  INT8_SIZE*MAX_VECTOR_SIZE  ADD data_o; lane i at bits [(i+1)*8-1 -: 8].
- add_valid_i  in  1  ADD valid_o.
- m_tdata_o  out  INT8_SIZE*MAX_VECTOR_SIZE  output vector.
- m_tkeep_o  out  MAX_VECTOR_SIZE  bit i set means lane i is valid.
- m_tlast_o  out  1  final vector of the job.
- m_tvalid_o  out  1  output valid.
- m_tready_i  in  1  consumer ready.
- overflow_o  out  1  sticky error.
- stray_o  out  1  sticky error.

Behaviour:
- Reset values: all outputs 0 except issue_ok_o=1.
  - credits=FIFO_DEPTH, FIFO empty, state=IDLE.
  - rst mid-job discards FIFO contents, in-flight accounting and the job, in one cycle.
- FSM
  - IDLE: start_i loads total_len_i. It goes to DONE if len=0, otherwise to RUN.
  - RUN: the accept counter expects ceil(len/MAX_VECTOR_SIZE) vectors. After the last vector is pushed it goes to DRAIN.
  - DRAIN: waits for the beat with tlast to handshake (tvalid&tready), then goes to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
  - busy_o=1 in RUN and DRAIN. start_i outside IDLE is ignored.
- Push (RUN only, on add_valid_i)
  - Let rem = total − 8·vectors_accepted.
  - If rem ≥ 8: keep=all ones, last=(rem==8).
  - Else: keep has bits [rem−1:0] set, last=1, and lanes ≥ rem are forced to 0 in the stored data.
  - {data, keep, last} is written to the FIFO.
  - add_valid_i in IDLE, DRAIN or DONE sets stray_o; the data is dropped.
- FIFO
  - Registered output; a push into an empty FIFO gives m_tvalid_o the next cycle.
  - Pop on tvalid&tready. Throughput is one vector per cycle.
  - tdata, tkeep and tlast stay stable while tvalid&!tready.
  - Push while full: accepted if a pop happens in the same cycle. Otherwise it is dropped and overflow_o is set.
- Credits
  - Counter range 0..FIFO_DEPTH.
  - −1 on issue_i, +1 on pop; both in the same cycle leaves it unchanged.
  - issue_ok_o = (credits≠0), driven from the register.
  - issue_i with credits=0 sets overflow_o and saturates the counter at 0.
  - Credits persist across jobs and are cleared only by rst.
- Sticky flags clear only on rst.
- Lengths
  - total_len_i is unsigned.
  - The vector count is computed without overflow for len up to 2^CNT_W−1, using the (len+7)>>3 form in CNT_W+1 bits.

Decomposition:
- params.vh (existing) supplies INT8_SIZE and INT32_SIZE.
- Add to it ADD_LANES=8 and the FSM state encodings (IDLE, RUN, DRAIN, DONE).
- Sub-module sync_fifo: generic width/depth, registered read, full/empty/count.
  - Instantiated with width 8·MAX_VECTOR_SIZE + MAX_VECTOR_SIZE + 1.
- Credit counter, keep/last generation and FSM stay in add_out_collector.

Test Plan:
- len=24, tready=1, three add_valid_i pulses on consecutive cycles:
  - three beats, keep=0xFF each, tlast only on the third beat;
  - done_o pulses one cycle after the third handshake.
- len=13, two vectors of 0x7F-filled lanes:
  - beat 2 has keep=0x1F, lanes 5–7 = 0x00, tlast=1.
- Backpressure, FIFO_DEPTH=4, tready=0:
  - after 4 issues issue_ok_o=0;
  - raising tready for 1 cycle restores issue_ok_o=1 the next cycle;
  - data order is preserved and tdata is stable while stalled.
- len=0 start:
  - done_o the next cycle, no tvalid, busy_o never high.
- Errors:
  - add_valid_i while IDLE → stray_o=1.
  - Forced push into a full FIFO with tready=0 → overflow_o=1.
  - rst clears both flags and restores credits=FIFO_DEPTH.
- rst asserted mid-job with 2 vectors buffered:
  - the next cycle has tvalid=0, busy_o=0, issue_ok_o=1;
  - a new len=8 job then completes normally.
